fetch_if_stage: RTL and testbench
=================================

// Module: fetch_if_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
//  Keeps the PC and fetches words from instruction memory over a req/ack handshake.
//  Presents instr_D/pc_D/pc4_D to the decode stage, where instr_D drives the field splitter.
//  Handles decode stall, decode flush, branch/jump redirect, and a one-entry skid buffer.
// PARAMETERS
//  RESET_PC   32'h0000_3000   PC value loaded on reset; bits [1:0] must be 0
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  word-aligned fetch address; held stable while imem_req=1
//  imem_ack     in   1   memory response; imem_rdata valid in the same cycle
//  imem_rdata   in   32  fetched instruction word
//  stall_D      in   1   decode stage holds; IF/ID registers must not change
//  flush_D      in   1   kill the instruction in IF/ID (insert bubble)
//  redirect     in   1   branch/jump taken; next fetch address is redirect_pc
//  redirect_pc  in   32  target address; bits [1:0] ignored (forced to 00)
//  instr_D      out  32  instruction to decode; 32'h0 (sll nop) when no valid instruction
//  pc_D         out  32  address of instr_D
//  pc4_D        out  32  pc_D + 4 (mod 2^32)
//  valid_D      out  1   instr_D holds a real, unflushed instruction
// BEHAVIOUR
//  Reset (async): pc_F=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC.
//   Also cleared: instr_D, pc_D, pc4_D, skid buffer, valid_D, drop flag.
//  States:
//   S_IDLE  - first cycle after rst_n release; goes to S_FETCH; imem_req=0.
//   S_FETCH - imem_req=1, imem_addr=pc_F.
//   S_DROP  - imem_req=1; the outstanding response is discarded on ack.
//   S_HOLD  - imem_req=0; skid holds an acked word that decode could not accept.
//  Handshake: a transfer completes on a rising edge with imem_req=1 && imem_ack=1.
//   imem_addr must not change while req=1 and not acked. An ack with req=0 is ignored.
//   With ack tied high: one instruction per cycle, back-to-back, no bubbles.
//  Ack in S_FETCH, no redirect:
//   - stall_D=0: IF/ID <= {rdata, pc_F, pc_F+4}, valid_D=1; pc_F += 4; stay in S_FETCH.
//   - stall_D=1: skid <= {rdata, pc_F}; pc_F += 4; go to S_HOLD.
//  S_HOLD with stall_D=0: IF/ID <= skid, valid_D=1; go to S_FETCH (req rises next cycle).
//  Decode not loaded and stall_D=0: IF/ID gets a bubble (instr_D=0, valid_D=0).
//   pc_D and pc4_D hold their previous values.
//  Priority on IF/ID registers: flush_D > stall_D > load.
//   - flush_D: instr_D=0, valid_D=0 next edge, even when stalled.
//   - flush_D does not touch pc_F, the skid buffer, or the outstanding request.
//  Redirect (next target = {redirect_pc[31:2],2'b00}):
//   - S_FETCH, no ack this cycle: pc_F <= target; go to S_DROP (address stays stable).
//   - S_FETCH with ack same cycle: rdata dropped, IF/ID not loaded.
//     pc_F <= target; stay in S_FETCH.
//   - S_DROP: on ack, data dropped, go to S_FETCH with pc_F.
//     A further redirect updates pc_F only.
//   - S_HOLD: skid invalidated, pc_F <= target, go to S_FETCH.
//   - S_IDLE: pc_F <= target.
//  Wrap-around: pc_F=32'hFFFF_FFFC + 4 -> 32'h0000_0000; pc4_D wraps the same way.
//  Reset mid-transaction: req drops immediately (async); any outstanding response is lost.
// TESTING
//  1. Reset, ack tied high, rdata=addr:
//     -> req rises 1 cycle after rst_n release.
//     -> pc_D = 3000, 3004, 3008 on consecutive cycles; valid_D=1 each cycle.
//  2. ack delayed 3 cycles on addr 3004:
//     -> imem_addr stays 3004 for 4 cycles.
//     -> IF/ID shows 3 bubbles (valid_D=0, instr_D=0), then pc_D=3004.
//  3. stall_D high 2 cycles during an ack of 3008:
//     -> IF/ID holds 3004; req low in S_HOLD.
//     -> after stall drops, pc_D=3008 next cycle, then fetch resumes at 300C.
//  4. redirect to 0x3100 while 300C is pending (ack 2 cycles later):
//     -> 300C data never appears on instr_D.
//     -> next request address is 0x3100; redirect_pc=0x3103 also yields 0x3100.
//  5. flush_D and stall_D asserted together:
//     -> valid_D=0, instr_D=0 next cycle.
//     -> flush with RESET_PC=FFFF_FFFC: pc4_D=0, next fetch address=0.
//  6. rst_n pulsed low mid-wait:
//     -> imem_req=0 and valid_D=0 asynchronously.
//     -> fetch restarts at RESET_PC; a late ack during reset is ignored.

Source files
------------

// File: rtl/fetch_if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Fetches over a req/ack handshake, with redirect, stall, flush and a one-entry skid buffer.
module fetch_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall_D,
   input  logic        flush_D,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr_D,
   output logic [31:0] pc_D,
   output logic [31:0] pc4_D,
   output logic        valid_D
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DROP,
      S_HOLD
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [31:0] r_pc;
   logic [31:0] w_pcNext;
   logic [31:0] r_dropAddr;
   logic [31:0] w_dropAddrNext;
   logic [31:0] r_skidInstr;
   logic [31:0] r_skidPc;
   logic [31:0] r_instrD;
   logic [31:0] r_pcD;
   logic [31:0] r_pc4D;
   logic        r_validD;
   logic [31:0] w_target;
   logic [31:0] w_pcInc;
   logic        w_xfer;
   logic        w_load;
   logic        w_skidWrite;
   logic [31:0] w_loadInstr;
   logic [31:0] w_loadPc;

   // In S_DROP the killed request keeps its address while r_pc already holds the target.
   assign imem_req  = (r_state == S_FETCH) || (r_state == S_DROP);
   assign imem_addr = (r_state == S_DROP) ? r_dropAddr : r_pc;
   assign w_xfer    = imem_req && imem_ack;
   assign w_target  = redirect_pc & 32'hFFFF_FFFC;
   assign w_pcInc   = r_pc + 32'd4;

   always_comb begin
      w_stateNext    = r_state;
      w_pcNext       = r_pc;
      w_dropAddrNext = r_dropAddr;
      w_load         = 1'b0;
      w_skidWrite    = 1'b0;
      w_loadInstr    = imem_rdata;
      w_loadPc       = r_pc;
      case (r_state)
         S_IDLE: begin
            w_stateNext = S_FETCH;
            if (redirect) w_pcNext = w_target;
         end
         S_FETCH: begin
            if (redirect) begin
               w_pcNext = w_target;
               if (!w_xfer) begin
                  w_stateNext    = S_DROP;
                  w_dropAddrNext = r_pc;
               end
            end else if (w_xfer) begin
               w_pcNext = w_pcInc;
               if (stall_D) begin
                  w_skidWrite = 1'b1;
                  w_stateNext = S_HOLD;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         S_DROP: begin
            if (redirect) w_pcNext = w_target;
            if (w_xfer) w_stateNext = S_FETCH;
         end
         S_HOLD: begin
            if (redirect) begin
               w_pcNext    = w_target;
               w_stateNext = S_FETCH;
            end else if (!stall_D) begin
               w_load      = 1'b1;
               w_loadInstr = r_skidInstr;
               w_loadPc    = r_skidPc;
               w_stateNext = S_FETCH;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_dropAddr <= RESET_PC;
      end else begin
         r_state    <= w_stateNext;
         r_pc       <= w_pcNext;
         r_dropAddr <= w_dropAddrNext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skidInstr <= 32'h0;
         r_skidPc    <= 32'h0;
      end else if (w_skidWrite) begin
         r_skidInstr <= imem_rdata;
         r_skidPc    <= r_pc;
      end
   end

   // Flush beats stall beats load; an unloaded, unstalled cycle becomes a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instrD <= 32'h0;
         r_pcD    <= 32'h0;
         r_pc4D   <= 32'h0;
         r_validD <= 1'b0;
      end else if (flush_D) begin
         r_instrD <= 32'h0;
         r_validD <= 1'b0;
      end else if (!stall_D) begin
         if (w_load) begin
            r_instrD <= w_loadInstr;
            r_pcD    <= w_loadPc;
            r_pc4D   <= w_loadPc + 32'd4;
            r_validD <= 1'b1;
         end else begin
            r_instrD <= 32'h0;
            r_validD <= 1'b0;
         end
      end
   end

   assign instr_D = r_instrD;
   assign pc_D    = r_pcD;
   assign pc4_D   = r_pc4D;
   assign valid_D = r_validD;

endmodule

// File: tb/tb_fetch_if_stage.sv
// Self-checking bench for fetch_if_stage: a transaction-level model checked every cycle,
// plus hand-computed expectations, and a second instance exercising PC wrap-around.
module tb_fetch_if_stage;

   localparam logic [31:0] KEY = 32'hC0DE_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        imem_ack;
   logic        stall_D;
   logic        flush_D;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic [31:0] pc4_D;
   logic        valid_D;

   logic        rst2_n;
   logic        stall2;
   logic        flush2;
   logic        req2;
   logic [31:0] addr2;
   logic [31:0] rdata2;
   logic [31:0] instr2;
   logic [31:0] pcD2;
   logic [31:0] pc4D2;
   logic        valid2;

   int cmpCount = 0;
   int errCount = 0;

   // Memory returns a word derived from its address so every fetch is identifiable.
   assign imem_rdata = imem_addr ^ KEY;
   assign rdata2     = addr2 ^ KEY;

   fetch_if_stage #(.RESET_PC(32'h0000_3000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall_D(stall_D), .flush_D(flush_D),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_D(instr_D), .pc_D(pc_D), .pc4_D(pc4_D), .valid_D(valid_D)
   );

   fetch_if_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .rst_n(rst2_n),
      .imem_req(req2), .imem_addr(addr2),
      .imem_ack(1'b1), .imem_rdata(rdata2),
      .stall_D(stall2), .flush_D(flush2),
      .redirect(1'b0), .redirect_pc(32'h0),
      .instr_D(instr2), .pc_D(pcD2), .pc4_D(pc4D2), .valid_D(valid2)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmpCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Model state: fetch pointer, whether the outstanding request is doomed, and a queue of
   // fetched-but-unaccepted words ({instr, pc}).
   logic        mStarted;
   logic        mKilled;
   logic [31:0] mPc;
   logic [31:0] mKilledAddr;
   logic [63:0] heldQ[$];
   logic [31:0] mInstr;
   logic [31:0] mPcD;
   logic [31:0] mPc4;
   logic        mValid;

   always @(posedge clk or negedge rst_n) begin
      logic        req, xfer, load;
      logic [31:0] tgt, addrNow, ldInstr, ldPc;
      if (!rst_n) begin
         mStarted = 1'b0; mKilled = 1'b0; mPc = 32'h3000; mKilledAddr = 32'h3000;
         heldQ.delete();
         mInstr = 32'h0; mPcD = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      end else begin
         addrNow = mKilled ? mKilledAddr : mPc;
         req     = mStarted && (heldQ.size() == 0);
         xfer    = req && imem_ack;
         tgt     = {redirect_pc[31:2], 2'b00};
         load    = 1'b0;
         ldInstr = 32'h0;
         ldPc    = 32'h0;
         if (!mStarted) begin
            mStarted = 1'b1;
            if (redirect) mPc = tgt;
         end else if (heldQ.size() != 0) begin
            if (redirect) begin
               heldQ.delete();
               mPc = tgt;
            end else if (!stall_D) begin
               {ldInstr, ldPc} = heldQ.pop_front();
               load = 1'b1;
            end
         end else if (mKilled) begin
            if (xfer) mKilled = 1'b0;
            if (redirect) mPc = tgt;
         end else if (redirect) begin
            if (!xfer) begin
               mKilled     = 1'b1;
               mKilledAddr = mPc;
            end
            mPc = tgt;
         end else if (xfer) begin
            if (stall_D) heldQ.push_back({addrNow ^ KEY, mPc});
            else begin
               load    = 1'b1;
               ldInstr = addrNow ^ KEY;
               ldPc    = mPc;
            end
            mPc = mPc + 32'd4;
         end
         if (flush_D) begin
            mInstr = 32'h0; mValid = 1'b0;
         end else if (!stall_D) begin
            if (load) begin
               mInstr = ldInstr; mPcD = ldPc; mPc4 = ldPc + 32'd4; mValid = 1'b1;
            end else begin
               mInstr = 32'h0; mValid = 1'b0;
            end
         end
      end
   end

   // Every falling edge, the main instance must agree with the model on all outputs.
   always @(negedge clk) begin
      checkOutput("req",     {31'h0, imem_req}, {31'h0, mStarted && (heldQ.size() == 0)});
      checkOutput("addr",    imem_addr, mKilled ? mKilledAddr : mPc);
      checkOutput("instr_D", instr_D, mInstr);
      checkOutput("pc_D",    pc_D, mPcD);
      checkOutput("pc4_D",   pc4_D, mPc4);
      checkOutput("valid_D", {31'h0, valid_D}, {31'h0, mValid});
   end

   task automatic applyStimulus(input logic ack, input logic stall, input logic flush,
                                input logic redir, input logic [31:0] rpc);
      imem_ack    = ack;
      stall_D     = stall;
      flush_D     = flush;
      redirect    = redir;
      redirect_pc = rpc;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b1; imem_ack = 1'b1; stall_D = 1'b0; flush_D = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0;
      rst2_n = 1'b0; stall2 = 1'b0; flush2 = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      checkOutput("idleReq", {31'h0, imem_req}, 32'h0);

      // Back-to-back fetch with ack tied high.
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("firstReq", {31'h0, imem_req}, 32'h1);
      checkOutput("firstAddr", imem_addr, 32'h3000);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("pcD3000", pc_D, 32'h3000);
      checkOutput("instr3000", instr_D, 32'h3000 ^ KEY);
      checkOutput("addr3004", imem_addr, 32'h3004);

      // Ack withheld for three cycles on 3004.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 32'h0);
         checkOutput("waitAddr", imem_addr, 32'h3004);
         checkOutput("bubbleValid", {31'h0, valid_D}, 32'h0);
         checkOutput("bubbleInstr", instr_D, 32'h0);
      end
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("pcD3004", pc_D, 32'h3004);
      checkOutput("pc4D3008", pc4_D, 32'h3008);

      // Stall for two cycles while 3008 is acked.
      applyStimulus(1, 1, 0, 0, 32'h0);
      checkOutput("holdPcD", pc_D, 32'h3004);
      checkOutput("holdReq", {31'h0, imem_req}, 32'h0);
      applyStimulus(1, 1, 0, 0, 32'h0);
      checkOutput("holdPcD2", pc_D, 32'h3004);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("skidPcD", pc_D, 32'h3008);
      checkOutput("resumeAddr", imem_addr, 32'h300C);

      // Redirect with 300C pending; its late ack is discarded.
      applyStimulus(0, 0, 0, 1, 32'h3103);
      checkOutput("dropAddr", imem_addr, 32'h300C);
      applyStimulus(0, 0, 0, 0, 32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("redirAddr", imem_addr, 32'h3100);
      checkOutput("dropValid", {31'h0, valid_D}, 32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("pcD3100", pc_D, 32'h3100);

      // Redirect coinciding with an ack, then a redirect out of the skid state.
      applyStimulus(1, 0, 0, 1, 32'h3200);
      checkOutput("ackRedirAddr", imem_addr, 32'h3200);
      applyStimulus(1, 0, 0, 0, 32'h0);
      applyStimulus(1, 1, 0, 0, 32'h0);
      applyStimulus(1, 1, 0, 1, 32'h3400);
      checkOutput("holdRedirAddr", imem_addr, 32'h3400);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("pcD3400", pc_D, 32'h3400);

      // Flush together with stall, then flush alone.
      applyStimulus(1, 1, 1, 0, 32'h0);
      checkOutput("flushValid", {31'h0, valid_D}, 32'h0);
      checkOutput("flushInstr", instr_D, 32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("pcD3404", pc_D, 32'h3404);
      applyStimulus(1, 0, 1, 0, 32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0);

      // Reset pulsed in the middle of a wait; a late ack during reset is ignored.
      applyStimulus(0, 0, 0, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncReq", {31'h0, imem_req}, 32'h0);
      checkOutput("asyncValid", {31'h0, valid_D}, 32'h0);
      checkOutput("asyncAddr", imem_addr, 32'h3000);
      imem_ack = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("restartAddr", imem_addr, 32'h3000);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("restartPcD", pc_D, 32'h3000);
      applyStimulus(1, 0, 0, 0, 32'h0);

      // Wrap-around instance starting at FFFF_FFFC.
      rst2_n = 1'b1;
      checkOutput("wrapIdleReq", {31'h0, req2}, 32'h0);
      @(posedge clk); #2;
      checkOutput("wrapFirstAddr", addr2, 32'hFFFF_FFFC);
      @(posedge clk); #2;
      checkOutput("wrapPcD", pcD2, 32'hFFFF_FFFC);
      checkOutput("wrapPc4D", pc4D2, 32'h0);
      checkOutput("wrapNextAddr", addr2, 32'h0);
      stall2 = 1'b1; flush2 = 1'b1;
      @(posedge clk); #2;
      checkOutput("wrapFlushValid", {31'h0, valid2}, 32'h0);
      checkOutput("wrapFlushInstr", instr2, 32'h0);
      checkOutput("wrapFlushPc4D", pc4D2, 32'h0);
      stall2 = 1'b0; flush2 = 1'b0;
      @(posedge clk); #2;
      checkOutput("wrapZeroPcD", pcD2, 32'h0);
      checkOutput("wrapZeroPc4D", pc4D2, 32'h4);
      checkOutput("wrapZeroInstr", instr2, KEY);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
